// File: rtl/multdiv_unit.sv
// Iterative signed 32-bit multiply (radix-2 Booth) / divide (non-restoring) unit.
// The divider is only built when MULTDIV_DIV_EN is defined; otherwise DIV completes with an exception.
module multdiv_unit (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic [4:0]  rd_in,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        busy,
  output logic [4:0]  rd_out
);

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [64:0] acc_q, acc_d;
  logic [31:0] mcand_q, mcand_d;
  logic [4:0]  rd_pend_q, rd_pend_d;
  logic [31:0] result_q, result_d;
  logic        exc_q, exc_d;
  logic [4:0]  rd_out_q, rd_out_d;

  // Booth step: 33-bit high sum so that subtracting -2^31 cannot wrap.
  logic [32:0] booth_hi;
  logic [32:0] booth_m;
  logic [32:0] booth_sum;
  logic [64:0] acc_step;
  logic [63:0] product;
  logic        mul_ovf;

  always_comb begin
    booth_hi = {acc_q[64], acc_q[64:33]};
    booth_m  = {mcand_q[31], mcand_q};
    unique case (acc_q[1:0])
      2'b01:   booth_sum = booth_hi + booth_m;
      2'b10:   booth_sum = booth_hi - booth_m;
      default: booth_sum = booth_hi;
    endcase
    acc_step = {booth_sum, acc_q[32:1]};
    product  = acc_q[64:1];
    mul_ovf  = !((&product[63:31]) || !(|product[63:31]));
  end

`ifdef MULTDIV_DIV_EN
  logic [33:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic        neg_q, neg_d;

  logic [33:0] rem_sh;
  logic [33:0] rem_new;
  logic [31:0] quo_fix;
  logic        div_ovf;
  logic [31:0] a_mag;
  logic [31:0] b_mag;

  always_comb begin
    a_mag   = data_operandA[31] ? (~data_operandA + 32'd1) : data_operandA;
    b_mag   = data_operandB[31] ? (~data_operandB + 32'd1) : data_operandB;
    rem_sh  = {rem_q[32:0], quo_q[31]};
    rem_new = rem_q[33] ? (rem_sh + {2'b00, dvs_q}) : (rem_sh - {2'b00, dvs_q});
    quo_fix = neg_q ? (~quo_q + 32'd1) : quo_q;
    // Only a same-sign 2^31 magnitude quotient is unrepresentable.
    div_ovf = !neg_q && quo_q[31];
  end
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    rd_pend_d = rd_pend_q;
    result_d  = result_q;
    exc_d     = exc_q;
    rd_out_d  = rd_out_q;
`ifdef MULTDIV_DIV_EN
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    neg_d     = neg_q;
`endif
    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (ctrl_MULT) begin
          state_d   = StMul;
          cnt_d     = 6'd0;
          acc_d     = {33'd0, data_operandB, 1'b0};
          mcand_d   = data_operandA;
          rd_pend_d = rd_in;
        end else if (ctrl_DIV) begin
          state_d   = StDiv;
          cnt_d     = 6'd0;
          rd_pend_d = rd_in;
`ifdef MULTDIV_DIV_EN
          rem_d     = 34'd0;
          quo_d     = a_mag;
          dvs_d     = b_mag;
          neg_d     = data_operandA[31] ^ data_operandB[31];
`endif
        end
      end
      StMul: begin
        if (cnt_q == 6'd32) begin
          state_d  = StDone;
          result_d = product[31:0];
          exc_d    = mul_ovf;
          rd_out_d = rd_pend_q;
        end else begin
          acc_d = acc_step;
          cnt_d = cnt_q + 6'd1;
        end
      end
      StDiv: begin
`ifdef MULTDIV_DIV_EN
        if (dvs_q == 32'd0) begin
          state_d  = StDone;
          result_d = 32'd0;
          exc_d    = 1'b1;
          rd_out_d = rd_pend_q;
        end else if (cnt_q == 6'd32) begin
          state_d  = StDone;
          result_d = quo_fix;
          exc_d    = div_ovf;
          rd_out_d = rd_pend_q;
        end else begin
          rem_d = rem_new;
          quo_d = {quo_q[30:0], ~rem_new[33]};
          cnt_d = cnt_q + 6'd1;
        end
`else
        state_d  = StDone;
        result_d = 32'd0;
        exc_d    = 1'b1;
        rd_out_d = rd_pend_q;
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      cnt_q     <= 6'd0;
      acc_q     <= 65'd0;
      mcand_q   <= 32'd0;
      rd_pend_q <= 5'd0;
      result_q  <= 32'd0;
      exc_q     <= 1'b0;
      rd_out_q  <= 5'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      rd_pend_q <= rd_pend_d;
      result_q  <= result_d;
      exc_q     <= exc_d;
      rd_out_q  <= rd_out_d;
    end
  end

`ifdef MULTDIV_DIV_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rem_q <= 34'd0;
      quo_q <= 32'd0;
      dvs_q <= 32'd0;
      neg_q <= 1'b0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
      neg_q <= neg_d;
    end
  end
`endif

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign rd_out         = rd_out_q;
  assign data_resultRDY = (state_q == StDone);
  assign busy           = (state_q == StMul) || (state_q == StDiv);

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed self-checking bench for multdiv_unit; DIV expectations follow MULTDIV_DIV_EN.
module tb_multdiv_unit;

`ifdef MULTDIV_DIV_EN
  localparam bit DivEn = 1'b1;
`else
  localparam bit DivEn = 1'b0;
`endif

  logic        clock;
  logic        reset_n;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [4:0]  rd_in;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;
  logic [4:0]  rd_out;

  int compares;
  int mismatches;
  int lat;
  int pulses;

  multdiv_unit dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .rd_in          (rd_in),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy),
    .rd_out         (rd_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compares++;
    assert (obs === exp) else begin
      mismatches++;
      $error("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drives a start so it is sampled on the next rising edge (E0); returns 1 time unit after E0.
  task automatic issue(input logic m, input logic d, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd);
    ctrl_MULT     = m;
    ctrl_DIV      = d;
    data_operandA = a;
    data_operandB = b;
    rd_in         = rd;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
  endtask

  // Counts edges after E0 until RDY is seen; -1 if the 40-edge budget expires.
  task automatic wait_rdy(output int n_edges);
    int n;
    n = 0;
    n_edges = -1;
    while (n_edges < 0 && n < 40) begin
      @(posedge clock);
      #1;
      n++;
      if (data_resultRDY) n_edges = n;
    end
  endtask

  task automatic count_rdy(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) cnt++;
    end
  endtask

  initial begin
    compares      = 0;
    mismatches    = 0;
    reset_n       = 1'b0;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = 32'd0;
    data_operandB = 32'd0;
    rd_in         = 5'd0;

    repeat (3) @(posedge clock);
    #1;
    check("rst_result", data_result, 32'd0);
    check("rst_exc", {31'd0, data_exception}, 32'd0);
    check("rst_rdy", {31'd0, data_resultRDY}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_rd", {27'd0, rd_out}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    check("idle_busy", {31'd0, busy}, 32'd0);

    // 7 * -3
    issue(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 5'd5);
    check("mul1_busy", {31'd0, busy}, 32'd1);
    wait_rdy(lat);
    check("mul1_lat", 32'(lat), 32'd33);
    check("mul1_result", data_result, 32'hFFFF_FFEB);
    check("mul1_exc", {31'd0, data_exception}, 32'd0);
    check("mul1_rd", {27'd0, rd_out}, 32'd5);
    check("mul1_busy_done", {31'd0, busy}, 32'd0);
    @(posedge clock);
    #1;
    check("mul1_rdy_one_cycle", {31'd0, data_resultRDY}, 32'd0);
    check("mul1_hold", data_result, 32'hFFFF_FFEB);

    // 2^16 * 2^16 overflows, then DIV -7 / 2 issued in the DONE cycle
    issue(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 5'd9);
    wait_rdy(lat);
    check("mul2_lat", 32'(lat), 32'd33);
    check("mul2_result", data_result, 32'd0);
    check("mul2_exc", {31'd0, data_exception}, 32'd1);
    issue(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 5'd12);
    wait_rdy(lat);
    check("div1_lat", 32'(lat), DivEn ? 32'd33 : 32'd1);
    check("div1_result", data_result, DivEn ? 32'hFFFF_FFFD : 32'd0);
    check("div1_exc", {31'd0, data_exception}, DivEn ? 32'd0 : 32'd1);
    check("div1_rd", {27'd0, rd_out}, 32'd12);

    // divide by zero
    @(negedge clock);
    issue(1'b0, 1'b1, 32'd5, 32'd0, 5'd3);
    wait_rdy(lat);
    check("div0_lat", 32'(lat), 32'd1);
    check("div0_result", data_result, 32'd0);
    check("div0_exc", {31'd0, data_exception}, 32'd1);
    check("div0_rd", {27'd0, rd_out}, 32'd3);

    // most-negative / -1
    @(negedge clock);
    issue(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4);
    wait_rdy(lat);
    check("divovf_lat", 32'(lat), DivEn ? 32'd33 : 32'd1);
    check("divovf_result", data_result, DivEn ? 32'h8000_0000 : 32'd0);
    check("divovf_exc", {31'd0, data_exception}, 32'd1);

    // 10 / 2
    @(negedge clock);
    issue(1'b0, 1'b1, 32'd10, 32'd2, 5'd6);
    wait_rdy(lat);
    check("div2_lat", 32'(lat), DivEn ? 32'd33 : 32'd1);
    check("div2_result", data_result, DivEn ? 32'd5 : 32'd0);
    check("div2_exc", {31'd0, data_exception}, DivEn ? 32'd0 : 32'd1);

    // -2^31 * -2^31 = 2^62
    @(negedge clock);
    issue(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 5'd1);
    wait_rdy(lat);
    check("mulmin_result", data_result, 32'd0);
    check("mulmin_exc", {31'd0, data_exception}, 32'd1);

    // -2^31 * 1 fits exactly
    @(negedge clock);
    issue(1'b1, 1'b0, 32'h8000_0000, 32'd1, 5'd2);
    wait_rdy(lat);
    check("mulneg_result", data_result, 32'h8000_0000);
    check("mulneg_exc", {31'd0, data_exception}, 32'd0);

    // both ctrl pulses: multiply wins
    @(negedge clock);
    issue(1'b1, 1'b1, 32'd6, 32'd7, 5'd10);
    wait_rdy(lat);
    check("both_lat", 32'(lat), 32'd33);
    check("both_result", data_result, 32'd42);
    check("both_exc", {31'd0, data_exception}, 32'd0);

    // second start at E5 is ignored
    @(negedge clock);
    issue(1'b1, 1'b0, 32'd100, 32'd3, 5'd7);
    repeat (4) @(posedge clock);
    #1;
    issue(1'b1, 1'b0, 32'd2, 32'd2, 5'd8);
    wait_rdy(lat);
    check("ign_lat", 32'(lat), 32'd28);
    check("ign_result", data_result, 32'd300);
    check("ign_rd", {27'd0, rd_out}, 32'd7);
    count_rdy(40, pulses);
    check("ign_no_second_rdy", 32'(pulses), 32'd0);

    // reset pulse at E10 of a new op
    @(negedge clock);
    issue(1'b1, 1'b0, 32'd3, 32'd3, 5'd11);
    repeat (10) @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check("mrst_result", data_result, 32'd0);
    check("mrst_exc", {31'd0, data_exception}, 32'd0);
    check("mrst_rdy", {31'd0, data_resultRDY}, 32'd0);
    check("mrst_busy", {31'd0, busy}, 32'd0);
    check("mrst_rd", {27'd0, rd_out}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    count_rdy(40, pulses);
    check("mrst_no_rdy", 32'(pulses), 32'd0);
    check("mrst_result_after", data_result, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mismatches);
    $finish;
  end

endmodule
